// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: divisor write port with accept/reject response pulses
interface clk_div_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH = 24,
    parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ack;
    logic             cfg_err;

    modport master (output cfg_wr, cfg_ch, cfg_div, input cfg_ack, cfg_err);
    modport slave (input cfg_wr, cfg_ch, cfg_div, output cfg_ack, cfg_err);
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel runtime-programmable divider with ticks; CLK_DIV_PHASE_SYNC_EN adds sync_all phase realignment
module clk_div_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH = 24,
    parameter int DEFAULT_DIV = 6000000,
    parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CLK_DIV_PHASE_SYNC_EN
    input  logic                sync_all,
`endif
    input  logic [CHANNELS-1:0] en,
    clk_div_multi_if.slave      bus,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);
    logic accept;
    logic sync;

    assign accept = bus.cfg_wr && bus.cfg_div != '0 && 32'(bus.cfg_ch) < CHANNELS;
`ifdef CLK_DIV_PHASE_SYNC_EN
    assign sync = sync_all;
`else
    assign sync = 1'b0;
`endif

    // write response: one-cycle ack or err after each sampled strobe
    always_ff @(posedge clk)
        if (rst) begin
            bus.cfg_ack <= 1'b0;
            bus.cfg_err <= 1'b0;
        end else begin
            bus.cfg_ack <= accept;
            bus.cfg_err <= bus.cfg_wr && !accept;
        end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] cnt, div, pend;
        logic             pv, lvl, tk, wrap, hit;

        assign wrap = en[c] && cnt == div - WIDTH'(1);
        assign hit  = accept && 32'(bus.cfg_ch) == c;
        assign clk_out[c] = lvl;
        assign tick[c]    = tk;

        // half-period counter; divisor swaps only at a wrap so no half-period is cut short
        always_ff @(posedge clk)
            if (rst) begin
                cnt  <= '0;
                div  <= WIDTH'(DEFAULT_DIV);
                pend <= '0;
                pv   <= 1'b0;
                lvl  <= 1'b0;
                tk   <= 1'b0;
            end else begin
                if (sync) begin
                    cnt <= '0;
                    lvl <= 1'b0;
                    tk  <= 1'b0;
                    pv  <= 1'b0;
                    if (pv) div <= pend;
                end else begin
                    tk <= wrap;
                    if (wrap) begin
                        cnt <= '0;
                        lvl <= ~lvl;
                        pv  <= 1'b0;
                        if (pv) div <= pend;
                    end else if (en[c]) cnt <= cnt + WIDTH'(1);
                end
                if (hit) begin
                    pend <= bus.cfg_div;
                    pv   <= 1'b1;
                end
            end
    end
endmodule
